// File: rtl/ibuffer.sv
// ---------------------------------------------------------------------------
// ibuffer : instruction buffer between the fetch-group output and decode.
//
// Each accepted fetch group carries INSTR_PER_FETCH slots plus a slot-valid
// mask. Only the valid slots are written into a circular queue of
// single-instruction entries, packed in slot order. Up to DECODE_WIDTH of the
// oldest entries are presented to decode every cycle with their PC and
// predicted next PC.
//
// Handshakes:
//   fetch  : a group is taken on a cycle where fe_valid_i & fe_ready_o and no
//            flush is requested. fe_ready_o depends on registered occupancy only
//            and never on fe_valid_i. The frontend holds a group while
//            fe_ready_o is low.
//   decode : dec_valid_o is a contiguous prefix of lanes. When dec_ready_i is
//            high (and no flush is requested) decode takes every valid lane.
//
// Ports:
//   clk_i, rst_ni    clock, synchronous active-low reset
//   flush_i          discard all buffered instructions (beats enqueue/dequeue)
//   fe_valid_i       fetch group valid
//   fe_ready_o       room for a full group
//   fe_data_i        slot instructions, slot 0 = lowest PC
//   fe_pc_i          PC of slot 0; slot s sits at fe_pc_i + 4*s
//   fe_slot_valid_i  per-slot valid mask
//   fe_pred_npc_i    per-slot predicted next PC
//   dec_valid_o      lane valid prefix
//   dec_ready_i      decode takes all valid lanes
//   dec_instr_o      lane instructions, lane 0 = oldest
//   dec_pc_o         lane PCs
//   dec_pred_npc_o   lane predicted next PCs
//   count_o          current occupancy
// ---------------------------------------------------------------------------
module ibuffer #(
    parameter int INSTR_PER_FETCH = 4,
    parameter int DECODE_WIDTH    = 4,
    parameter int DEPTH           = 16,
    parameter int ILEN            = 32,
    parameter int PLEN            = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic                             fe_valid_i,
    output logic                             fe_ready_o,
    input  logic [INSTR_PER_FETCH*ILEN-1:0]  fe_data_i,
    input  logic [PLEN-1:0]                  fe_pc_i,
    input  logic [INSTR_PER_FETCH-1:0]       fe_slot_valid_i,
    input  logic [INSTR_PER_FETCH*PLEN-1:0]  fe_pred_npc_i,
    output logic [DECODE_WIDTH-1:0]          dec_valid_o,
    input  logic                             dec_ready_i,
    output logic [DECODE_WIDTH*ILEN-1:0]     dec_instr_o,
    output logic [DECODE_WIDTH*PLEN-1:0]     dec_pc_o,
    output logic [DECODE_WIDTH*PLEN-1:0]     dec_pred_npc_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o
);

    localparam int PTRW  = $clog2(DEPTH);
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int SLOTW = $clog2(INSTR_PER_FETCH + 1);

    // Entry storage; intentionally not reset, lanes are masked by occupancy.
    logic [ILEN-1:0] mem_instr [DEPTH];
    logic [PLEN-1:0] mem_pc    [DEPTH];
    logic [PLEN-1:0] mem_npc   [DEPTH];

    logic [PTRW-1:0] head;
    logic [PTRW-1:0] tail;
    logic [CNTW-1:0] count;

    logic             push_en;
    logic             pop_en;
    logic [SLOTW-1:0] push_cnt;
    logic [CNTW-1:0]  push_amt;
    logic [CNTW-1:0]  pop_amt;
    logic [PTRW-1:0]  wr_idx [INSTR_PER_FETCH];

    // Room for a whole group, judged on registered occupancy only.
    assign fe_ready_o = (CNTW'(DEPTH) - count) >= CNTW'(INSTR_PER_FETCH);
    assign push_en    = fe_valid_i & fe_ready_o & ~flush_i;
    assign pop_en     = dec_ready_i & ~flush_i;
    assign count_o    = count;

    // Compaction: slot s lands at tail + (number of valid slots below s).
    always_comb begin
        logic [SLOTW-1:0] offs;
        offs = '0;
        for (int s = 0; s < INSTR_PER_FETCH; s++) begin
            wr_idx[s] = tail + PTRW'(offs);
            offs      = offs + SLOTW'(fe_slot_valid_i[s]);
        end
        push_cnt = offs;
    end

    assign push_amt = push_en ? CNTW'(push_cnt) : '0;
    assign pop_amt  = !pop_en ? '0
                    : (count > CNTW'(DECODE_WIDTH)) ? CNTW'(DECODE_WIDTH) : count;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PTRW'(push_amt);
            head  <= head + PTRW'(pop_amt);
            count <= count + push_amt - pop_amt;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int s = 0; s < INSTR_PER_FETCH; s++) begin
            if (rst_ni && push_en && fe_slot_valid_i[s]) begin
                mem_instr[wr_idx[s]] <= fe_data_i[s*ILEN +: ILEN];
                mem_pc[wr_idx[s]]    <= fe_pc_i + PLEN'(4 * s);
                mem_npc[wr_idx[s]]   <= fe_pred_npc_i[s*PLEN +: PLEN];
            end
        end
    end

    // Decode lanes read registered state only: no fall-through from fetch.
    always_comb begin
        logic [PTRW-1:0] rd_idx;
        dec_valid_o    = '0;
        dec_instr_o    = '0;
        dec_pc_o       = '0;
        dec_pred_npc_o = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            rd_idx = head + PTRW'(i);
            if (count > CNTW'(i)) begin
                dec_valid_o[i]                  = 1'b1;
                dec_instr_o[i*ILEN +: ILEN]     = mem_instr[rd_idx];
                dec_pc_o[i*PLEN +: PLEN]        = mem_pc[rd_idx];
                dec_pred_npc_o[i*PLEN +: PLEN]  = mem_npc[rd_idx];
            end
        end
    end

    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        int'(count) <= DEPTH);
    a_valid_prefix : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((dec_valid_o & (dec_valid_o + DECODE_WIDTH'(1))) == '0));
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (fe_valid_i && !fe_ready_o) |-> (int'(count) + int'(push_amt) <= DEPTH));
    a_push_fits : assert property (@(posedge clk_i) disable iff (!rst_ni)
        push_en |-> (int'(count) + int'(push_cnt) <= DEPTH));

endmodule

// File: tb/tb_ibuffer.sv
// ---------------------------------------------------------------------------
// tb_ibuffer : directed scenarios followed by random traffic, all checked
// against a queue model of the instruction stream (one entry per valid slot).
// ---------------------------------------------------------------------------
module tb_ibuffer;

    localparam int IPF   = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 16;
    localparam int ILEN  = 32;
    localparam int PLEN  = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 fe_valid;
    logic                 fe_ready;
    logic [IPF*ILEN-1:0]  fe_data;
    logic [PLEN-1:0]      fe_pc;
    logic [IPF-1:0]       fe_mask;
    logic [IPF*PLEN-1:0]  fe_npc;
    logic [DW-1:0]        dec_valid;
    logic                 dec_ready;
    logic [DW*ILEN-1:0]   dec_instr;
    logic [DW*PLEN-1:0]   dec_pc;
    logic [DW*PLEN-1:0]   dec_npc;
    logic [4:0]           count;

    // Expected stream: {instr, pc, pred_npc}, oldest at index 0.
    logic [ILEN+2*PLEN-1:0] exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    ibuffer #(
        .INSTR_PER_FETCH(IPF), .DECODE_WIDTH(DW), .DEPTH(DEPTH),
        .ILEN(ILEN), .PLEN(PLEN)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .fe_valid_i(fe_valid), .fe_ready_o(fe_ready),
        .fe_data_i(fe_data), .fe_pc_i(fe_pc),
        .fe_slot_valid_i(fe_mask), .fe_pred_npc_i(fe_npc),
        .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
        .dec_instr_o(dec_instr), .dec_pc_o(dec_pc),
        .dec_pred_npc_o(dec_npc), .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's view of the current state.
    task automatic check_outputs(input string tag);
        int sz;
        logic [DW-1:0] v;
        logic [ILEN+2*PLEN-1:0] e;
        sz = exp_q.size();
        v  = '0;
        for (int i = 0; i < DW; i++) v[i] = (i < sz);
        check({tag, ".count"}, 64'(count), 64'(sz));
        check({tag, ".ready"}, 64'(fe_ready), 64'((DEPTH - sz) >= IPF));
        check({tag, ".valid"}, 64'(dec_valid), 64'(v));
        for (int i = 0; i < DW; i++) begin
            e = (i < sz) ? exp_q[i] : '0;
            check($sformatf("%s.instr%0d", tag, i), 64'(dec_instr[i*ILEN +: ILEN]),
                  64'(e[2*PLEN +: ILEN]));
            check($sformatf("%s.pc%0d", tag, i), 64'(dec_pc[i*PLEN +: PLEN]),
                  64'(e[PLEN +: PLEN]));
            check($sformatf("%s.npc%0d", tag, i), 64'(dec_npc[i*PLEN +: PLEN]),
                  64'(e[0 +: PLEN]));
        end
    endtask

    // One clock: check outputs, drive inputs, then apply the model's rules
    // at the edge. Entered and left at the falling edge.
    task automatic cyc(input string tag, input logic r, input logic f, input logic v,
                       input logic [IPF-1:0] m, input logic [PLEN-1:0] pc,
                       input logic dr);
        int sz;
        int n;
        bit acc;
        check_outputs(tag);
        rst_n    = r;
        flush    = f;
        fe_valid = v;
        fe_mask  = m;
        fe_pc    = pc;
        dec_ready = dr;
        for (int s = 0; s < IPF; s++) begin
            fe_data[s*ILEN +: ILEN] = $urandom;
            fe_npc[s*PLEN +: PLEN]  = $urandom;
        end
        @(posedge clk);
        sz = exp_q.size();
        if (!r || f) begin
            exp_q.delete();
        end else begin
            acc = v && ((DEPTH - sz) >= IPF);
            n   = dr ? ((sz < DW) ? sz : DW) : 0;
            for (int k = 0; k < n; k++) void'(exp_q.pop_front());
            if (acc) begin
                for (int s = 0; s < IPF; s++) begin
                    if (m[s]) exp_q.push_back({fe_data[s*ILEN +: ILEN],
                                               PLEN'(pc + 32'(4 * s)),
                                               fe_npc[s*PLEN +: PLEN]});
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; fe_valid = 1'b0; fe_mask = '0;
        fe_pc = '0; dec_ready = 1'b0; fe_data = '0; fe_npc = '0;

        // Reset held for two edges before any check.
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        check("rst.ready", 64'(fe_ready), 64'(1));
        check("rst.valid", 64'(dec_valid), 64'(0));
        check("rst.count", 64'(count), 64'(0));
        check("rst.pc0", 64'(dec_pc[31:0]), 64'(0));

        // Masked group: slot 2 is dropped and D packs into lane 2.
        cyc("s2a", 1, 0, 1, 4'b1011, 32'h8000_0000, 0);
        check("s2.valid", 64'(dec_valid), 64'(4'b0111));
        check("s2.count", 64'(count), 64'(3));
        check("s2.pc0", 64'(dec_pc[31:0]), 64'h8000_0000);
        check("s2.pc1", 64'(dec_pc[63:32]), 64'h8000_0004);
        check("s2.pc2", 64'(dec_pc[95:64]), 64'h8000_000C);
        check("s2.instr2", 64'(dec_instr[95:64]), 64'(fe_data[127:96]));
        cyc("s2b", 1, 0, 0, 4'b0000, 32'h0, 1);

        // Fill to the brim with decode stalled; a 5th group must stall.
        for (int g = 0; g < 4; g++) begin
            cyc($sformatf("s3g%0d", g), 1, 0, 1, 4'b1111, 32'h1000 + 32'(16 * g), 0);
            if (g == 2) begin
                check("s3.count12", 64'(count), 64'(12));
                check("s3.ready12", 64'(fe_ready), 64'(1));
            end
        end
        check("s3.count16", 64'(count), 64'(16));
        check("s3.ready16", 64'(fe_ready), 64'(0));
        cyc("s3stall", 1, 0, 1, 4'b1111, 32'h2000, 0);
        check("s3.stalled", 64'(count), 64'(16));

        // Wrap: move head to 12, refill across index 15->0, then push + pop.
        cyc("s4rst", 0, 0, 0, 4'b0000, 32'h0, 0);
        for (int g = 0; g < 3; g++) cyc("s4f", 1, 0, 1, 4'b1111, 32'h3000 + 32'(16 * g), 0);
        for (int g = 0; g < 3; g++) cyc("s4d", 1, 0, 0, 4'b0000, 32'h0, 1);
        check("s4.empty", 64'(count), 64'(0));
        for (int g = 0; g < 3; g++) cyc("s4w", 1, 0, 1, 4'b1111, 32'h4000 + 32'(16 * g), 0);
        cyc("s4pp", 1, 0, 1, 4'b0011, 32'h5000, 1);
        check("s4.count10", 64'(count), 64'(10));
        check("s4.wrap_pc0", 64'(dec_pc[31:0]), 64'h4010);
        cyc("s4full", 1, 0, 1, 4'b1111, 32'h6000, 0);
        check("s4.count14", 64'(count), 64'(14));
        check("s4.ready14", 64'(fe_ready), 64'(0));
        cyc("s4drain", 1, 0, 0, 4'b0000, 32'h0, 0);

        // Flush with 9 entries while fetch and decode are both active.
        cyc("s5rst", 0, 0, 0, 4'b0000, 32'h0, 0);
        cyc("s5a", 1, 0, 1, 4'b1111, 32'h7000, 0);
        cyc("s5b", 1, 0, 1, 4'b1111, 32'h7010, 0);
        cyc("s5c", 1, 0, 1, 4'b0100, 32'h7020, 0);
        check("s5.count9", 64'(count), 64'(9));
        cyc("s5flush", 1, 1, 1, 4'b1111, 32'h7030, 1);
        check("s5.count0", 64'(count), 64'(0));
        check("s5.valid0", 64'(dec_valid), 64'(0));
        check("s5.ready1", 64'(fe_ready), 64'(1));

        // Random traffic, including rare flushes and a rare mid-run reset.
        for (int c = 0; c < 10000; c++) begin
            cyc("rnd",
                ($urandom_range(0, 999) != 0),
                ($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) != 0),
                IPF'($urandom_range(0, 15)),
                {$urandom, 2'b00},
                ($urandom_range(0, 2) != 0));
        end
        check_outputs("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
